// File: rtl/decode_round_controller_pkg.sv
// Shared types and default sizing for the decode round controller and its host interface.
// The round FSM states follow the order a single decoding round walks through them.
package decode_round_controller_pkg;

    localparam int DEFAULT_PE_COUNT          = 16;
    localparam int DEFAULT_MATCH_VALUE_WIDTH = 8;
    localparam int DEFAULT_SETTLE_CYCLES     = 40;
    localparam int DEFAULT_QUIET_CYCLES      = 16;
    localparam int DEFAULT_MAX_OFFER_CYCLES  = 4096;
    localparam int DEFAULT_COLLECT_CYCLES    = 2;
    localparam int DEFAULT_COUNT_WIDTH       = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_START   = 3'd3,
        ST_OFFER   = 3'd4,
        ST_STOP    = 3'd5,
        ST_COLLECT = 3'd6,
        ST_DONE    = 3'd7
    } round_state_e;

endpackage

// File: rtl/decode_round_controller_if.sv
// Host-side round request/result bundle of the decode round controller.
// The host owns the master modport; the controller owns the slave modport.
interface decode_round_controller_if
    import decode_round_controller_pkg::*;
#(
    parameter int PE_COUNT          = DEFAULT_PE_COUNT,
    parameter int MATCH_VALUE_WIDTH = DEFAULT_MATCH_VALUE_WIDTH,
    parameter int COUNT_WIDTH       = DEFAULT_COUNT_WIDTH
);

    logic                                  round_start_in;
    logic [PE_COUNT-1:0]                   syndrome_in;
    logic                                  round_busy_out;
    logic                                  round_done_out;
    logic                                  timeout_out;
    logic [COUNT_WIDTH-1:0]                offer_cycles_out;
    logic [PE_COUNT*MATCH_VALUE_WIDTH-1:0] match_values_out;

    modport master (
        output round_start_in,
        output syndrome_in,
        input  round_busy_out,
        input  round_done_out,
        input  timeout_out,
        input  offer_cycles_out,
        input  match_values_out
    );

    modport slave (
        input  round_start_in,
        input  syndrome_in,
        output round_busy_out,
        output round_done_out,
        output timeout_out,
        output offer_cycles_out,
        output match_values_out
    );

endinterface

// File: rtl/decode_round_controller_phase_counter.sv
// Loadable down-counter whose done flag marks the final cycle of a fixed-length phase.
// A phase loaded with N raises done on its Nth cycle; a load value of 0 never completes.
module phase_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    output logic             done_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_value_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done_o = (count_q == WIDTH'(1));

endmodule

// File: rtl/decode_round_controller.sv
// Sequences one decoding round over the PE mesh: load syndrome, settle, offer until
// the mesh links go quiet or time out, stop, then snapshot every PE's match value.
module decode_round_controller
    import decode_round_controller_pkg::*;
#(
    parameter int PE_COUNT          = DEFAULT_PE_COUNT,
    parameter int MATCH_VALUE_WIDTH = DEFAULT_MATCH_VALUE_WIDTH,
    parameter int SETTLE_CYCLES     = DEFAULT_SETTLE_CYCLES,
    parameter int QUIET_CYCLES      = DEFAULT_QUIET_CYCLES,
    parameter int MAX_OFFER_CYCLES  = DEFAULT_MAX_OFFER_CYCLES,
    parameter int COLLECT_CYCLES    = DEFAULT_COLLECT_CYCLES,
    parameter int COUNT_WIDTH       = DEFAULT_COUNT_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  reset,
    decode_round_controller_if.slave              bus,
    output logic [PE_COUNT-1:0]                   measurement_value_out,
    output logic                                  measurement_valid_out,
    output logic                                  start_offer_out,
    output logic                                  stop_offer_out,
    input  logic [PE_COUNT-1:0]                   link_active_in,
    input  logic [PE_COUNT*MATCH_VALUE_WIDTH-1:0] match_value_in
);

    localparam logic [COUNT_WIDTH-1:0] SETTLE_LOAD  = COUNT_WIDTH'(SETTLE_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] COLLECT_LOAD = COUNT_WIDTH'(COLLECT_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] QUIET_LIMIT  = COUNT_WIDTH'(QUIET_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] OFFER_LIMIT  = COUNT_WIDTH'(MAX_OFFER_CYCLES);

    round_state_e                          state_q;
    logic [PE_COUNT-1:0]                   meas_value_q;
    logic                                  meas_valid_q;
    logic                                  start_offer_q;
    logic                                  stop_offer_q;
    logic                                  busy_q;
    logic                                  done_q;
    logic                                  timeout_q;
    logic [COUNT_WIDTH-1:0]                offer_cycles_q;
    logic [COUNT_WIDTH-1:0]                quiet_q;
    logic [COUNT_WIDTH-1:0]                offer_q;
    logic [COUNT_WIDTH-1:0]                quiet_d;
    logic [COUNT_WIDTH-1:0]                offer_d;
    logic [PE_COUNT*MATCH_VALUE_WIDTH-1:0] match_values_q;

    logic                                  phase_load;
    logic [COUNT_WIDTH-1:0]                phase_value;
    logic                                  phase_done;

    // One counter times both fixed phases: loaded leaving LOAD for SETTLE, leaving STOP for COLLECT.
    always_comb begin
        phase_load  = (state_q == ST_LOAD) || (state_q == ST_STOP);
        phase_value = (state_q == ST_LOAD) ? SETTLE_LOAD : COLLECT_LOAD;
    end

    phase_counter #(
        .WIDTH (COUNT_WIDTH)
    ) u_phase_counter (
        .clk          (clk),
        .reset        (reset),
        .load_i       (phase_load),
        .load_value_i (phase_value),
        .done_o       (phase_done)
    );

    always_comb begin
        quiet_d = (|link_active_in) ? '0 : quiet_q + 1'b1;
        offer_d = (offer_q == '1) ? offer_q : offer_q + 1'b1;
    end

    // Round FSM; every output is a register written on the edge that enters the state it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            meas_value_q   <= '0;
            meas_valid_q   <= 1'b0;
            start_offer_q  <= 1'b0;
            stop_offer_q   <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            timeout_q      <= 1'b0;
            offer_cycles_q <= '0;
            quiet_q        <= '0;
            offer_q        <= '0;
            match_values_q <= '0;
        end else begin
            meas_value_q  <= '0;
            meas_valid_q  <= 1'b0;
            start_offer_q <= 1'b0;
            stop_offer_q  <= 1'b0;
            done_q        <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.round_start_in) begin
                        state_q        <= ST_LOAD;
                        meas_value_q   <= bus.syndrome_in;
                        meas_valid_q   <= 1'b1;
                        busy_q         <= 1'b1;
                        timeout_q      <= 1'b0;
                        offer_cycles_q <= '0;
                    end
                end
                ST_LOAD: begin
                    state_q <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (phase_done) begin
                        state_q       <= ST_START;
                        start_offer_q <= 1'b1;
                    end
                end
                ST_START: begin
                    // The START cycle is the first cycle of the offer phase but not of the quiet window.
                    state_q <= ST_OFFER;
                    quiet_q <= '0;
                    offer_q <= COUNT_WIDTH'(1);
                end
                ST_OFFER: begin
                    quiet_q <= quiet_d;
                    offer_q <= offer_d;
                    if (quiet_d == QUIET_LIMIT) begin
                        state_q        <= ST_STOP;
                        stop_offer_q   <= 1'b1;
                        offer_cycles_q <= offer_d;
                    end else if (offer_d == OFFER_LIMIT) begin
                        state_q        <= ST_STOP;
                        stop_offer_q   <= 1'b1;
                        offer_cycles_q <= offer_d;
                        timeout_q      <= 1'b1;
                    end
                end
                ST_STOP: begin
                    state_q <= ST_COLLECT;
                end
                ST_COLLECT: begin
                    if (phase_done) begin
                        state_q        <= ST_DONE;
                        match_values_q <= match_value_in;
                        done_q         <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign measurement_value_out = meas_value_q;
    assign measurement_valid_out = meas_valid_q;
    assign start_offer_out       = start_offer_q;
    assign stop_offer_out        = stop_offer_q;
    assign bus.round_busy_out    = busy_q;
    assign bus.round_done_out    = done_q;
    assign bus.timeout_out       = timeout_q;
    assign bus.offer_cycles_out  = offer_cycles_q;
    assign bus.match_values_out  = match_values_q;

endmodule

// File: tb/tb_decode_round_controller.sv
// Bench for decode_round_controller: a round-timeline model checked every cycle,
// plus directed rounds pinned with hand-computed cycle offsets and values.
module tb_decode_round_controller;

    localparam int PE      = 16;
    localparam int MW      = 8;
    localparam int CW      = 16;
    localparam int SETTLE  = 40;
    localparam int QUIET   = 16;
    localparam int MAXOFF  = 4096;
    localparam int COLLECT = 2;
    localparam int VW      = PE * MW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [PE-1:0] meas_value;
    logic          meas_valid;
    logic          start_offer;
    logic          stop_offer;
    logic [PE-1:0] link_active;
    logic [VW-1:0] match_in;

    always #5 clk = ~clk;

    decode_round_controller_if host_if ();

    decode_round_controller #(
        .PE_COUNT          (PE),
        .MATCH_VALUE_WIDTH (MW),
        .SETTLE_CYCLES     (SETTLE),
        .QUIET_CYCLES      (QUIET),
        .MAX_OFFER_CYCLES  (MAXOFF),
        .COLLECT_CYCLES    (COLLECT),
        .COUNT_WIDTH       (CW)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .bus                   (host_if),
        .measurement_value_out (meas_value),
        .measurement_valid_out (meas_valid),
        .start_offer_out       (start_offer),
        .stop_offer_out        (stop_offer),
        .link_active_in        (link_active),
        .match_value_in        (match_in)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared = 0;
    int mismatched = 0;

    task automatic checkOutput(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
        end
    endtask

    // Round timeline model: a round accepted in cycle t0 shows LOAD at t0+1, START at
    // t0+2+SETTLE, then STOP once QUIET idle offer cycles accumulate or the offer phase
    // (measured from the START cycle) reaches MAXOFF; DONE comes COLLECT+1 cycles after STOP.
    bit            hasRound = 1'b0;
    int            t0m = 0;
    int            stopAt = -1;
    int            quietRun = 0;
    int            offerLen = 0;
    logic [PE-1:0] synExp = '0;
    logic          timeoutExp = 1'b0;
    logic [CW-1:0] offerExp = '0;
    logic [VW-1:0] matchExp = '0;
    logic          expValid, expStart, expStop, expDone, expBusy;

    int            lastValidAt = 0, lastStartAt = 0, lastStopAt = 0, lastDoneAt = 0;
    int            validCount = 0, startCount = 0, stopCount = 0, doneCount = 0;
    logic [PE-1:0] lastValidValue = '0;
    logic [CW-1:0] doneOffer = '0;
    logic          doneTimeout = 1'b0;
    logic [VW-1:0] doneMatch = '0;

    initial forever begin
        @(negedge clk);
        if (cyc >= 1) begin
            expValid = hasRound && (cyc == t0m + 1);
            expStart = hasRound && (cyc == t0m + 2 + SETTLE);
            expStop  = hasRound && (stopAt >= 0) && (cyc == stopAt);
            expDone  = hasRound && (stopAt >= 0) && (cyc == stopAt + COLLECT + 1);
            expBusy  = hasRound && (cyc >= t0m + 1) && ((stopAt < 0) || (cyc <= stopAt + COLLECT + 1));
            checkOutput("measurement_valid", VW'(meas_valid), VW'(expValid));
            checkOutput("measurement_value", VW'(meas_value), expValid ? VW'(synExp) : '0);
            checkOutput("start_offer", VW'(start_offer), VW'(expStart));
            checkOutput("stop_offer", VW'(stop_offer), VW'(expStop));
            checkOutput("round_done", VW'(host_if.round_done_out), VW'(expDone));
            checkOutput("round_busy", VW'(host_if.round_busy_out), VW'(expBusy));
            checkOutput("timeout", VW'(host_if.timeout_out), VW'(timeoutExp));
            checkOutput("offer_cycles", VW'(host_if.offer_cycles_out), VW'(offerExp));
            checkOutput("match_values", host_if.match_values_out, matchExp);

            if (meas_valid) begin
                lastValidAt = cyc;
                lastValidValue = meas_value;
                validCount++;
            end
            if (start_offer) begin
                lastStartAt = cyc;
                startCount++;
            end
            if (stop_offer) begin
                lastStopAt = cyc;
                stopCount++;
            end
            if (host_if.round_done_out) begin
                lastDoneAt = cyc;
                doneOffer = host_if.offer_cycles_out;
                doneTimeout = host_if.timeout_out;
                doneMatch = host_if.match_values_out;
                doneCount++;
            end

            if (reset) begin
                hasRound = 1'b0;
                stopAt = -1;
                quietRun = 0;
                timeoutExp = 1'b0;
                offerExp = '0;
                matchExp = '0;
            end else begin
                if (hasRound && (stopAt < 0) && (cyc >= t0m + 3 + SETTLE)) begin
                    if (|link_active) quietRun = 0;
                    else quietRun++;
                    offerLen = cyc + 1 - (t0m + 2 + SETTLE);
                    if (quietRun == QUIET) begin
                        stopAt = cyc + 1;
                        offerExp = CW'(offerLen);
                        timeoutExp = 1'b0;
                    end else if (offerLen == MAXOFF) begin
                        stopAt = cyc + 1;
                        offerExp = CW'(offerLen);
                        timeoutExp = 1'b1;
                    end
                end
                if (hasRound && (stopAt >= 0) && (cyc == stopAt + COLLECT)) matchExp = match_in;
                if ((!hasRound || ((stopAt >= 0) && (cyc > stopAt + COLLECT + 1))) && host_if.round_start_in) begin
                    hasRound = 1'b1;
                    t0m = cyc;
                    stopAt = -1;
                    quietRun = 0;
                    synExp = host_if.syndrome_in;
                    timeoutExp = 1'b0;
                    offerExp = '0;
                end
            end
        end
    end

    task automatic applyStimulus(input logic [PE-1:0] syn, output int t0v);
        @(posedge clk);
        #1;
        host_if.round_start_in = 1'b1;
        host_if.syndrome_in = syn;
        t0v = cyc;
        @(posedge clk);
        #1;
        host_if.round_start_in = 1'b0;
    endtask

    task automatic waitDone(input int prev, input int budget, input string name);
        int n = 0;
        while ((doneCount == prev) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        if (doneCount == prev) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s: no round_done within %0d cycles, required one", name, budget);
        end
    endtask

    task automatic waitStart(input int prev, input int budget, input string name);
        int n = 0;
        while ((startCount == prev) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        if (startCount == prev) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s: no start_offer within %0d cycles, required one", name, budget);
        end
    endtask

    int t0, prevD, prevS, prevV, prevStop, lastActive;

    initial begin
        host_if.round_start_in = 1'b0;
        host_if.syndrome_in = '0;
        link_active = '0;
        match_in = '0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset busy", VW'(host_if.round_busy_out), '0);
        checkOutput("reset offer_cycles", VW'(host_if.offer_cycles_out), '0);

        $display("[TB] basic round");
        prevD = doneCount;
        applyStimulus(16'h0001, t0);
        waitDone(prevD, 200, "basic");
        checkOutput("basic valid offset", VW'(lastValidAt - t0), VW'(1));
        checkOutput("basic valid value", VW'(lastValidValue), VW'(16'h0001));
        checkOutput("basic start offset", VW'(lastStartAt - t0), VW'(42));
        checkOutput("basic stop offset", VW'(lastStopAt - t0), VW'(59));
        checkOutput("basic done offset", VW'(lastDoneAt - t0), VW'(62));
        checkOutput("basic offer_cycles", VW'(doneOffer), VW'(17));
        checkOutput("basic timeout", VW'(doneTimeout), VW'(0));

        $display("[TB] activity extends offer");
        prevD = doneCount;
        prevS = startCount;
        applyStimulus(16'h8421, t0);
        waitStart(prevS, 100, "activity start");
        @(posedge clk);
        #1;
        link_active = 16'h0008;
        repeat (99) begin
            @(posedge clk);
            #1;
        end
        lastActive = cyc;
        @(posedge clk);
        #1;
        link_active = '0;
        waitDone(prevD, 300, "activity");
        checkOutput("activity stop after drop", VW'(lastStopAt - lastActive), VW'(17));
        checkOutput("activity offer_cycles", VW'(doneOffer), VW'(117));

        $display("[TB] timeout round");
        link_active = '1;
        prevD = doneCount;
        applyStimulus(16'hFFFF, t0);
        waitDone(prevD, 4300, "timeout");
        checkOutput("timeout flag", VW'(doneTimeout), VW'(1));
        checkOutput("timeout offer_cycles", VW'(doneOffer), VW'(4096));
        checkOutput("timeout stop-start", VW'(lastStopAt - lastStartAt), VW'(4096));
        link_active = '0;
        prevD = doneCount;
        applyStimulus(16'h1234, t0);
        @(negedge clk);
        checkOutput("restart clears timeout", VW'(host_if.timeout_out), '0);
        checkOutput("restart clears offer_cycles", VW'(host_if.offer_cycles_out), '0);
        waitDone(prevD, 200, "after timeout");
        checkOutput("after timeout flag", VW'(doneTimeout), VW'(0));

        $display("[TB] match capture");
        match_in = {PE{8'h3C}};
        match_in[47:40] = 8'hA5;
        prevD = doneCount;
        applyStimulus(16'h0020, t0);
        waitDone(prevD, 200, "match");
        checkOutput("match PE5 at done", VW'(doneMatch[47:40]), VW'(8'hA5));
        checkOutput("match PE4 at done", VW'(doneMatch[39:32]), VW'(8'h3C));
        match_in = '0;
        repeat (5) @(negedge clk);
        checkOutput("match PE5 held", VW'(host_if.match_values_out[47:40]), VW'(8'hA5));

        $display("[TB] start while busy");
        prevD = doneCount;
        prevV = validCount;
        prevS = startCount;
        applyStimulus(16'h00F0, t0);
        waitStart(prevS, 100, "busy start");
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        host_if.round_start_in = 1'b1;
        @(posedge clk);
        #1;
        host_if.round_start_in = 1'b0;
        waitDone(prevD, 200, "busy");
        repeat (60) @(negedge clk);
        checkOutput("busy single done", VW'(doneCount - prevD), VW'(1));
        checkOutput("busy single load", VW'(validCount - prevV), VW'(1));

        $display("[TB] reset mid-offer");
        prevS = startCount;
        prevStop = stopCount;
        prevD = doneCount;
        applyStimulus(16'h0F00, t0);
        waitStart(prevS, 100, "reset start");
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset mid busy", VW'(host_if.round_busy_out), '0);
        checkOutput("reset mid offer_cycles", VW'(host_if.offer_cycles_out), '0);
        repeat (30) @(negedge clk);
        checkOutput("reset mid no stop", VW'(stopCount - prevStop), '0);
        checkOutput("reset mid no done", VW'(doneCount - prevD), '0);
        prevD = doneCount;
        applyStimulus(16'h0001, t0);
        waitDone(prevD, 200, "post reset");
        checkOutput("post reset start offset", VW'(lastStartAt - t0), VW'(42));
        checkOutput("post reset stop offset", VW'(lastStopAt - t0), VW'(59));
        checkOutput("post reset done offset", VW'(lastDoneAt - t0), VW'(62));
        checkOutput("post reset offer_cycles", VW'(doneOffer), VW'(17));

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
